mul_seq: RTL and testbench
==========================

# mul_seq

Iterative multi-cycle multiplier sequencer for the in-order RISC-V pipeline's execute stage. It accepts RV32M multiply operations (mul, mulh, mulhsu, mulhu), as encoded on the ALU control bus by the decoder, and computes them with a radix-2 shift-add datapath over 33 clock edges. It stalls the upstream pipeline while busy and presents the 32-bit result with a one-cycle done pulse. Flushes from branch or jump resolution abort an in-flight operation.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` input, 1 bit: clock, rising-edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: execute stage holds a valid instruction. Qualified internally by `aluCtrl`.
- `aluCtrl` input, 5 bits: ALU operation code.
  - 5'b01010: mul
  - 5'b01011: mulh
  - 5'b01101: mulhsu
  - 5'b01100: mulhu
  - Any other value: not a multiply.
- `flush` input, 1 bit: kill the execute-stage instruction.
- `srcA` input, 32 bits: rs1 operand.
- `srcB` input, 32 bits: rs2 operand.
- `stall` output, 1 bit: hold IF/ID/EX. Combinational.
- `done` output, 1 bit: result valid this cycle. Registered, single-cycle pulse.
- `result` output, 32 bits: multiply result. Registered; holds until the next completion.

## Operation
- `isMul` = `aluCtrl` is one of the four codes above. `go` = `start & isMul & ~flush`.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `go`: latch the op type.
  - `aSign` = `srcA[31]` for mulh and mulhsu, else 0. `bSign` = `srcB[31]` for mulh, else 0.
  - Latch `mcand` = |srcA| zero-extended to 64 bits, `mplier` = |srcB|. Each operand's magnitude is taken only if its sign flag is set. |0x80000000| = 0x80000000 unsigned.
  - Latch `neg` = `aSign ^ bSign`. Clear the 64-bit accumulator `acc` and the 5-bit counter `cnt`. Go to CALC.
- CALC, once per edge:
  - If `mplier[0]`: `acc` += `mcand`.
  - Then `mcand` <<= 1, `mplier` >>= 1, `cnt` += 1.
  - After the edge where `cnt` wraps 31→0 (the 32nd CALC edge), go to FIX.
- FIX, one edge:
  - `p` = `neg` ? (~`acc` + 1) : `acc`, in 64-bit two's complement.
  - `result` <= `p[31:0]` for mul, `p[63:32]` otherwise.
  - Go to DONE.
- DONE, one cycle:
  - `done` = 1, `stall` = 0.
  - `start` is ignored, because the same instruction is still in EX.
  - Next state is IDLE.
- Abort: `flush` = 1 in CALC or FIX returns the block to IDLE on the next edge. No `done` is raised and `result` is unchanged. `flush` in DONE has no effect on DONE→IDLE.
- `stall` = (IDLE & `go`) | CALC | FIX. `stall` is 0 in IDLE without `go`, and 0 in DONE.
- Non-multiply `aluCtrl` with `start`: no state change, `stall` = 0.
- Latency is fixed and independent of operand values. There is no early-out on zero operands.

## Timing
- Reset, asynchronous, any state: state = IDLE, `done` = 0, `result` = 0, `acc`/`mcand`/`mplier` = 0, `cnt` = 0, `neg` = 0.
- Reset mid-operation aborts immediately, with no done pulse.
- Edge numbering: E0 is the first edge with `go` = 1.
  - CALC occupies edges E1–E32.
  - FIX executes at E33.
  - `done` is high between E33 and E34.
  - The pipeline advances at E34.
- `stall` is high from the cycle `go` rises through the cycle before E33's state change: 34 stalled cycles.
- Back-to-back multiplies: the next instruction reaches EX after E34. The block is in IDLE then and accepts it with no bubble beyond its own latency.
- Same-cycle `start` and `flush` in IDLE: `flush` wins, no operation starts.
- Operands are sampled only at E0. Changes on `srcA`/`srcB` afterward are ignored.

## Test plan
- mul, `srcA` = 7, `srcB` = 0xFFFFFFFD (−3) → `done` at the cycle after E33, `result` = 0xFFFFFFEB, `stall` high for exactly 34 cycles.
- mulh, 0x80000000 × 0x80000000 → `result` = 0x40000000. mulh, 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- mulhsu, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. mulhu, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- `flush` at E10 during mul → IDLE at E11, no `done`, `result` keeps its prior value, `stall` low from E11.
- `rst` pulsed at E20 mid-mulhu → all outputs 0 immediately. A new mul after reset completes correctly.
- `start` with `aluCtrl` = 5'b00000 (add) → `stall` = 0, `done` = 0 throughout. Two consecutive muls (3×5, then 6×7) → results 15 and 42, each with a single `done` pulse.

Source files
------------

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV32M mul/mulh/mulhsu/mulhu.
// Stalls the pipeline for 34 cycles and pulses done with the registered result.
module mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      aluCtrl,
    input  logic            flush,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01100;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [4:0]        cnt;
    logic              neg;
    logic              low_half;

    logic              is_mul;
    logic              go;
    logic              a_sign;
    logic              b_sign;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        is_mul = 1'b0;
        case (aluCtrl)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_mul = 1'b1;
            default:                              is_mul = 1'b0;
        endcase
    end

    assign go     = start & is_mul & ~flush;
    assign a_sign = ((aluCtrl == OP_MULH) || (aluCtrl == OP_MULHSU)) & srcA[XLEN-1];
    assign b_sign = (aluCtrl == OP_MULH) & srcB[XLEN-1];
    // Magnitude of the most negative value wraps back to itself, which is correct as unsigned.
    assign a_mag  = a_sign ? (~srcA + 1'b1) : srcA;
    assign b_mag  = b_sign ? (~srcB + 1'b1) : srcB;
    assign prod   = neg ? (~acc + 1'b1) : acc;

    assign stall  = ((state == IDLE) & go) | (state == CALC) | (state == FIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            low_half <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        low_half <= (aluCtrl == OP_MUL);
                        neg      <= a_sign ^ b_sign;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= low_half ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // The completing instruction is still in EX, so start is not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: vector table of multiplies plus flush, reset and
// non-multiply sequences.
module tb_mul_seq;

    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01100;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  aluCtrl;
    logic        flush;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    mul_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .aluCtrl(aluCtrl),
        .flush  (flush),
        .srcA   (srcA),
        .srcB   (srcB),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issues one multiply, holds start until done, and checks result, latency,
    // stall length and that done is a single pulse.
    task automatic run_op(input string name, input logic [4:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        int stalls;
        logic [31:0] got;
        lat    = -1;
        stalls = 0;
        got    = 'x;
        @(negedge clk);
        aluCtrl = ctrl;
        srcA    = a;
        srcB    = b;
        start   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k == 1) begin
                srcA = ~a;
                srcB = a ^ b ^ 32'h5A5A_A5A5;
            end
            #1;
            if (stall) stalls++;
            if (done) begin
                lat = k;
                got = result;
                break;
            end
            @(negedge clk);
        end
        start   = 1'b0;
        aluCtrl = 5'b00000;
        check({name, "_result"}, got, exp);
        check({name, "_latency"}, lat, 34);
        check({name, "_stall_cycles"}, stalls, 34);
        @(negedge clk);
        #1;
        check({name, "_done_single"}, done, 0);
        check({name, "_stall_after"}, stall, 0);
    endtask

    initial begin
        int bad;
        logic [31:0] prior;

        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5]  = '{OP_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002};
        vecs[6]  = '{OP_MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[7]  = '{OP_MULH,   32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[9]  = '{OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[10] = '{OP_MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
        vecs[11] = '{OP_MUL,    32'h0000_0006, 32'h0000_0007, 32'h0000_002A};

        rst     = 1'b1;
        start   = 1'b0;
        aluCtrl = 5'b00000;
        flush   = 1'b0;
        srcA    = '0;
        srcB    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // Non-multiply op with start held: no stall, no done.
        aluCtrl = 5'b00000;
        srcA    = 32'd3;
        srcB    = 32'd4;
        start   = 1'b1;
        bad     = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (stall || done) bad++;
            @(negedge clk);
        end
        start = 1'b0;
        check("nonmul_stall_done", bad, 0);

        // Start and flush together in IDLE: flush wins.
        aluCtrl = OP_MUL;
        start   = 1'b1;
        flush   = 1'b1;
        bad     = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (stall || done) bad++;
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (stall || done) bad++;
            @(negedge clk);
        end
        check("start_flush_idle", bad, 0);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Flush mid-CALC: abort, no done, result unchanged.
        prior = 32'h0000_002A;
        @(negedge clk);
        aluCtrl = OP_MUL;
        srcA    = 32'd9;
        srcB    = 32'd9;
        start   = 1'b1;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1;
        check("flush_cycle_stall", stall, 1);
        @(negedge clk);
        flush   = 1'b0;
        aluCtrl = 5'b00000;
        #1;
        check("flush_stall_low", stall, 0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || stall) bad++;
            @(negedge clk);
            #1;
        end
        check("flush_no_done", bad, 0);
        check("flush_result_kept", result, prior);

        // Reset mid-mulhu: outputs clear immediately, then a fresh mul works.
        @(negedge clk);
        aluCtrl = OP_MULHU;
        srcA    = 32'hFFFF_FFFF;
        srcB    = 32'hFFFF_FFFF;
        start   = 1'b1;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        start   = 1'b0;
        aluCtrl = 5'b00000;
        rst     = 1'b1;
        #1;
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (done || stall) bad++;
            @(negedge clk);
        end
        check("midrst_quiet", bad, 0);
        run_op("post_reset_mul", OP_MUL, 32'd6, 32'd7, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
